d2l_slave: RTL and testbench

D2L_SLAVE -- requirements
Module: d2l_slave

---
 rtl/d2l_pkg.sv | 12 +
 rtl/d2l_sync.sv | 26 ++
 rtl/d2l_slave.sv | 145 ++++++++++++++
 tb/tb_d2l_slave.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/d2l_pkg.sv
// Shared definitions for the dual-lane (D2L) serial link, used by master and slave.
package d2l_pkg;

  localparam int LANE_W = 4;
  localparam int BEAT_W = 8;

  typedef enum logic {
    IDLE,
    RECV
  } d2l_state_t;

endpackage

// File: rtl/d2l_sync.sv
// Multi-flop synchronizer for a bus of link inputs; every bit sees the same depth.
module d2l_sync #(
  parameter int             W       = 1,
  parameter int             STAGES  = 2,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] chain [STAGES];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= RST_VAL;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/d2l_slave.sv
// D2L link receiver: oversamples sclk/CS/lanes in the clk domain, assembles
// WORD_BEATS-byte words and hands them out through a valid/ready holding register.
module d2l_slave
  import d2l_pkg::*;
#(
  parameter int WORD_BEATS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         sclk,
  input  logic                         CS,
  input  logic [LANE_W-1:0]            DL0,
  input  logic [LANE_W-1:0]            DL1,
  output logic [BEAT_W*WORD_BEATS-1:0] rx_data,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         busy,
  output logic                         frame_err,
  output logic                         overflow,
  input  logic                         clr_err
);

  localparam int         WORD_W    = BEAT_W * WORD_BEATS;
  localparam logic [2:0] LAST_BEAT = 3'(WORD_BEATS - 1);

  // Stage p0: synchronized link inputs (CS idles high, the rest idle low)
  logic              cs_p0;
  logic              sclk_p0;
  logic [LANE_W-1:0] dl0_p0;
  logic [LANE_W-1:0] dl1_p0;
  logic [BEAT_W-1:0] beat_p0;

  d2l_sync #(.W(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rstn (rstn),
    .d    (CS),
    .q    (cs_p0)
  );

  d2l_sync #(.W(1 + 2*LANE_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_link (
    .clk  (clk),
    .rstn (rstn),
    .d    ({sclk, DL1, DL0}),
    .q    ({sclk_p0, dl1_p0, dl0_p0})
  );

  assign beat_p0 = {dl1_p0, dl0_p0};

  // Stage p1: previous samples for edge detection
  logic                   sclk_p1;
  logic                   cs_p1;
  logic [SYNC_STAGES-1:0] sync_vld;
  logic                   armed;

  // armed demands a genuine CS-high sample after reset, so a frame that was
  // already running when reset released can never look like a fresh falling edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sclk_p1  <= 1'b0;
      cs_p1    <= 1'b1;
      sync_vld <= '0;
      armed    <= 1'b0;
    end else begin
      sclk_p1  <= sclk_p0;
      cs_p1    <= cs_p0;
      sync_vld <= {sync_vld[SYNC_STAGES-2:0], 1'b1};
      if (sync_vld[SYNC_STAGES-1] && cs_p0) armed <= 1'b1;
    end
  end

  d2l_state_t        state, state_nxt;
  logic [2:0]        beat_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] word_c;
  logic              cs_fall;
  logic              beat_vld_p0;
  logic              word_done;
  logic              frame_abort;
  logic              hs;

  assign cs_fall     = armed & cs_p1 & ~cs_p0;
  assign beat_vld_p0 = (state == RECV) & ~cs_p0 & sclk_p0 & ~sclk_p1;
  assign word_done   = beat_vld_p0 & (beat_cnt == LAST_BEAT);
  assign frame_abort = (state == RECV) & cs_p0 & (beat_cnt != 3'd0);
  assign hs          = rx_valid & rx_ready;
  assign busy        = (state == RECV);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cs_fall) state_nxt = RECV;
      RECV:    if (cs_p0)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Current beat merged into the partial word; on the last beat this is the full word.
  always_comb begin
    word_c = shift_reg;
    word_c[BEAT_W*beat_cnt +: BEAT_W] = beat_p0;
  end

  always_ff @(posedge clk) begin
    if (beat_vld_p0) shift_reg <= word_c;
  end

  // Stage p2: frame control, holding register and sticky flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != RECV || cs_p0)
        beat_cnt <= '0;
      else if (beat_vld_p0)
        beat_cnt <= (beat_cnt == LAST_BEAT) ? 3'd0 : beat_cnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else if (word_done && (!rx_valid || hs)) begin
      rx_data  <= word_c;
      rx_valid <= 1'b1;
    end else if (hs) begin
      rx_valid <= 1'b0;
    end
  end

  // A new error event outranks a coincident clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= frame_abort | (frame_err & ~clr_err);
      overflow  <= (word_done & rx_valid & ~hs) | (overflow & ~clr_err);
    end
  end

endmodule

// File: tb/tb_d2l_slave.sv
// Self-checking bench for d2l_slave: directed link scenarios plus randomized
// frames scored against a queue of the words the master sent.
module tb_d2l_slave;

  localparam int WB  = 4;
  localparam int SYN = 2;

  logic          clk = 1'b0;
  logic          rstn;
  logic          sclk;
  logic          CS;
  logic [3:0]    DL0;
  logic [3:0]    DL1;
  logic [8*WB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          busy;
  logic          frame_err;
  logic          overflow;
  logic          clr_err;

  int            n_checks = 0;
  int            n_errors = 0;
  int            hs_cnt   = 0;
  int            ready_mode = 0;   // 0 hold low, 1 hold high, 2 random, 3 driven by main thread
  logic [31:0]   exp_q[$];
  logic [31:0]   w, w1, w2;
  int            h0;
  logic          exp_ferr;

  always #5 clk = ~clk;

  d2l_slave #(.WORD_BEATS(WB), .SYNC_STAGES(SYN)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .sclk      (sclk),
    .CS        (CS),
    .DL0       (DL0),
    .DL1       (DL1),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clr_err   (clr_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_beat(input logic [7:0] b);
    DL1 = b[7:4];
    DL0 = b[3:0];
    clks($urandom_range(2, 4));
    sclk = 1'b1;
    clks($urandom_range(2, 4));
    sclk = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] wd, input int nb = WB);
    for (int k = 0; k < nb; k++) send_beat(wd[8*k +: 8]);
  endtask

  task automatic cs_start();
    CS = 1'b0;
    clks(4);
  endtask

  task automatic cs_end();
    clks(4);
    CS = 1'b1;
    clks(8);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    clks(1);
    clr_err = 1'b0;
  endtask

  // Consumer: every accepted word must be the oldest word still expected.
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       rx_ready = 1'b0;
        1:       rx_ready = 1'b1;
        2:       rx_ready = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
      #1;
      if (ready_mode != 3 && rstn && rx_valid && rx_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) check("rx_spurious", rx_valid, 1'b0);
        else                   check("rx_word", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    rstn = 1'b0; CS = 1'b1; sclk = 1'b0; DL0 = '0; DL1 = '0;
    rx_ready = 1'b0; clr_err = 1'b0;
    clks(3);
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    rstn = 1'b1;
    clks(6);

    // Single word, beats 0x12 0x34 0x56 0x78
    ready_mode = 1;
    h0 = hs_cnt;
    exp_q.push_back(32'h78563412);
    cs_start();
    send_beat(8'h12); send_beat(8'h34); send_beat(8'h56); send_beat(8'h78);
    check("busy_recv", busy, 1);
    cs_end();
    check("single_hs_count", hs_cnt - h0, 1);
    check("single_drained", exp_q.size(), 0);
    check("busy_idle", busy, 0);
    check("single_no_ferr", frame_err, 0);

    // Backpressure: second word dropped
    ready_mode = 0;
    clks(1);
    cs_start();
    send_word(32'hA5A5A5A5);
    send_word(32'h0F0F0F0F);
    cs_end();
    check("bp_valid", rx_valid, 1);
    check("bp_data", rx_data, 32'hA5A5A5A5);
    check("bp_overflow", overflow, 1);
    exp_q.push_back(32'hA5A5A5A5);
    ready_mode = 1;
    clks(4);
    check("bp_drained", exp_q.size(), 0);
    check("bp_valid_low", rx_valid, 0);
    pulse_clr();
    check("ovf_clr", overflow, 0);

    // Early release after two beats
    h0 = hs_cnt;
    cs_start();
    send_beat(8'h11); send_beat(8'h22);
    cs_end();
    check("early_ferr", frame_err, 1);
    check("early_no_word", hs_cnt - h0, 0);
    check("early_valid", rx_valid, 0);
    w = $urandom;
    exp_q.push_back(w);
    cs_start(); send_word(w); cs_end();
    check("after_early_drained", exp_q.size(), 0);
    pulse_clr();
    check("ferr_clr", frame_err, 0);

    // clr_err in the very cycle an early release is detected
    cs_start();
    send_beat(8'h33); send_beat(8'h44);
    clks(4);
    CS = 1'b1;
    clks(SYN);
    check("ferr_pre", frame_err, 0);
    clr_err = 1'b1;
    clks(1);
    clr_err = 1'b0;
    check("ferr_coincident", frame_err, 1);
    clks(8);

    // Reset in mid-frame while a word is held
    ready_mode = 0;
    clks(1);
    w1 = $urandom;
    w  = $urandom;
    cs_start();
    send_word(w1);
    send_beat(w[7:0]); send_beat(w[15:8]);
    check("rst_pre_valid", rx_valid, 1);
    rstn = 1'b0;
    clks(2);
    check("midrst_valid", rx_valid, 0);
    check("midrst_data", rx_data, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ferr", frame_err, 0);
    check("midrst_ovf", overflow, 0);
    rstn = 1'b1;
    ready_mode = 1;
    h0 = hs_cnt;
    send_beat(w[23:16]); send_beat(w[31:24]);
    send_word($urandom);
    check("midrst_not_resumed", busy, 0);
    cs_end();
    check("midrst_ignored", hs_cnt - h0, 0);
    check("midrst_no_ferr", frame_err, 0);
    exp_q.push_back(32'hDEADBEEF);
    cs_start(); send_word(32'hDEADBEEF); cs_end();
    check("deadbeef_drained", exp_q.size(), 0);

    // Handshake in the same cycle the next word loads
    ready_mode = 3;
    rx_ready = 1'b0;
    w1 = $urandom;
    w2 = $urandom;
    cs_start();
    send_word(w1);
    send_word(w2, WB - 1);
    DL1 = w2[31:28];
    DL0 = w2[27:24];
    clks(3);
    sclk = 1'b1;
    clks(SYN);
    check("sim_pre_valid", rx_valid, 1);
    check("sim_pre_data", rx_data, w1);
    rx_ready = 1'b1;
    clks(1);
    rx_ready = 1'b0;
    check("sim_valid", rx_valid, 1);
    check("sim_data", rx_data, w2);
    check("sim_ovf", overflow, 0);
    clks(3);
    sclk = 1'b0;
    cs_end();
    exp_q.push_back(w2);
    ready_mode = 1;
    clks(4);
    check("sim_drained", exp_q.size(), 0);

    // Random frames, random consumer stalls, occasional early release
    pulse_clr();
    exp_ferr = 1'b0;
    ready_mode = 2;
    for (int f = 0; f < 12; f++) begin
      cs_start();
      for (int i = 0; i < int'($urandom_range(1, 3)); i++) begin
        w = $urandom;
        exp_q.push_back(w);
        send_word(w);
      end
      if ($urandom_range(0, 3) == 0) begin
        exp_ferr = 1'b1;
        send_word($urandom, int'($urandom_range(1, WB - 1)));
      end
      cs_end();
    end
    ready_mode = 1;
    clks(6);
    check("rand_drained", exp_q.size(), 0);
    check("rand_ferr", frame_err, exp_ferr);
    check("rand_ovf", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
